// File: rtl/probe_unit.sv
// rtl/probe_unit.sv - sequences one TileLink Probe through metadata read, shrink, ack/writeback and metadata write
// Optional feature macro: PROBE_MSHR_BLOCK_EN (adds mshr_block_probe and stalls CHECK while it is high).
module probe_unit #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = ADDR_W - IDX_W - 6,
    parameter int WAYS   = 4,
    parameter int SRC_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_param,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [SRC_W-1:0]  b_source,
    output logic              meta_read_valid,
    input  logic              meta_read_ready,
    output logic [IDX_W-1:0]  meta_read_idx,
    output logic [TAG_W-1:0]  meta_read_tag,
    input  logic [WAYS-1:0]   meta_way_en,
    input  logic [1:0]        meta_state,
    output logic              c_valid,
    input  logic              c_ready,
    output logic [2:0]        c_param,
    output logic [ADDR_W-1:0] c_address,
    output logic [SRC_W-1:0]  c_source,
    output logic              wb_req_valid,
    input  logic              wb_req_ready,
    output logic [2:0]        wb_req_param,
    output logic [WAYS-1:0]   wb_req_way_en,
    output logic [IDX_W-1:0]  wb_req_idx,
    output logic [TAG_W-1:0]  wb_req_tag,
    output logic [SRC_W-1:0]  wb_req_source,
    input  logic              wb_done,
    output logic              meta_write_valid,
    input  logic              meta_write_ready,
    output logic [IDX_W-1:0]  meta_write_idx,
    output logic [WAYS-1:0]   meta_write_way_en,
    output logic [TAG_W-1:0]  meta_write_tag,
    output logic [1:0]        meta_write_state,
`ifdef PROBE_MSHR_BLOCK_EN
    input  logic              mshr_block_probe,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_META_READ, S_META_RESP, S_CHECK,
        S_RELEASE, S_WB_REQ, S_WB_RESP, S_META_WRITE
    } state_t;

    state_t            state;
    logic [1:0]        cap_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SRC_W-1:0]  src_q;
    logic              hit_q;
    logic [WAYS-1:0]   way_q;
    logic              data_q;
    logic [2:0]        report_q;
    logic [1:0]        new_q;

    logic              blocked;
    logic [1:0]        resp_state;
    logic              sh_data;
    logic [2:0]        sh_report;
    logic [1:0]        sh_new;

`ifdef PROBE_MSHR_BLOCK_EN
    assign blocked = mshr_block_probe;
`else
    assign blocked = 1'b0;
`endif

    // A miss is treated as Nothing regardless of what the array reports.
    assign resp_state = (|meta_way_en) ? meta_state : 2'd0;

    always_comb begin
        sh_data   = 1'b0;
        sh_report = 3'd5;
        sh_new    = 2'd0;
        case (resp_state)
            2'd3, 2'd2: begin
                sh_data = (resp_state == 2'd3);
                case (cap_q)
                    2'd0:    begin sh_report = 3'd3; sh_new = 2'd2; end
                    2'd1:    begin sh_report = 3'd0; sh_new = 2'd1; end
                    default: begin sh_report = 3'd1; sh_new = 2'd0; end
                endcase
            end
            2'd1: begin
                if (cap_q == 2'd0 || cap_q == 2'd1) begin
                    sh_report = 3'd4;
                    sh_new    = 2'd1;
                end else begin
                    sh_report = 3'd2;
                    sh_new    = 2'd0;
                end
            end
            default: begin
                sh_report = 3'd5;
                sh_new    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            b_ready          <= 1'b1;
            meta_read_valid  <= 1'b0;
            c_valid          <= 1'b0;
            wb_req_valid     <= 1'b0;
            meta_write_valid <= 1'b0;
            cap_q            <= '0;
            addr_q           <= '0;
            src_q            <= '0;
            hit_q            <= 1'b0;
            way_q            <= '0;
            data_q           <= 1'b0;
            report_q         <= '0;
            new_q            <= '0;
        end else begin
            case (state)
                S_IDLE: if (b_valid) begin
                    cap_q           <= b_param;
                    addr_q          <= b_address;
                    src_q           <= b_source;
                    b_ready         <= 1'b0;
                    meta_read_valid <= 1'b1;
                    state           <= S_META_READ;
                end
                S_META_READ: if (meta_read_ready) begin
                    meta_read_valid <= 1'b0;
                    state           <= S_META_RESP;
                end
                S_META_RESP: begin
                    hit_q    <= |meta_way_en;
                    way_q    <= meta_way_en;
                    data_q   <= sh_data;
                    report_q <= sh_report;
                    new_q    <= sh_new;
                    state    <= S_CHECK;
                end
                S_CHECK: if (!blocked) begin
                    if (data_q) begin
                        wb_req_valid <= 1'b1;
                        state        <= S_WB_REQ;
                    end else begin
                        c_valid <= 1'b1;
                        state   <= S_RELEASE;
                    end
                end
                S_RELEASE: if (c_ready) begin
                    c_valid <= 1'b0;
                    if (hit_q) begin
                        meta_write_valid <= 1'b1;
                        state            <= S_META_WRITE;
                    end else begin
                        b_ready <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_WB_REQ: if (wb_req_ready) begin
                    wb_req_valid <= 1'b0;
                    state        <= S_WB_RESP;
                end
                S_WB_RESP: if (wb_done) begin
                    meta_write_valid <= 1'b1;
                    state            <= S_META_WRITE;
                end
                S_META_WRITE: if (meta_write_ready) begin
                    meta_write_valid <= 1'b0;
                    b_ready          <= 1'b1;
                    state            <= S_IDLE;
                end
                default: begin
                    b_ready <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign busy              = (state != S_IDLE);
    assign meta_read_idx     = addr_q[IDX_W+5:6];
    assign meta_read_tag     = addr_q[ADDR_W-1:IDX_W+6];
    assign c_param           = report_q;
    assign c_address         = addr_q;
    assign c_source          = src_q;
    assign wb_req_param      = report_q;
    assign wb_req_way_en     = way_q;
    assign wb_req_idx        = addr_q[IDX_W+5:6];
    assign wb_req_tag        = addr_q[ADDR_W-1:IDX_W+6];
    assign wb_req_source     = src_q;
    assign meta_write_idx    = addr_q[IDX_W+5:6];
    assign meta_write_way_en = way_q;
    assign meta_write_tag    = addr_q[ADDR_W-1:IDX_W+6];
    assign meta_write_state  = new_q;

endmodule

// File: tb/tb_probe_unit.sv
// tb/tb_probe_unit.sv - scoreboard bench for probe_unit (directed timing cases plus randomized probes)
module tb_probe_unit;

    logic        clock;
    logic        reset;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_param;
    logic [31:0] b_address;
    logic [3:0]  b_source;
    logic        meta_read_valid;
    logic        meta_read_ready;
    logic [5:0]  meta_read_idx;
    logic [19:0] meta_read_tag;
    logic [3:0]  meta_way_en;
    logic [1:0]  meta_state;
    logic        c_valid;
    logic        c_ready;
    logic [2:0]  c_param;
    logic [31:0] c_address;
    logic [3:0]  c_source;
    logic        wb_req_valid;
    logic        wb_req_ready;
    logic [2:0]  wb_req_param;
    logic [3:0]  wb_req_way_en;
    logic [5:0]  wb_req_idx;
    logic [19:0] wb_req_tag;
    logic [3:0]  wb_req_source;
    logic        wb_done = 1'b0;
    logic        meta_write_valid;
    logic        meta_write_ready;
    logic [5:0]  meta_write_idx;
    logic [3:0]  meta_write_way_en;
    logic [19:0] meta_write_tag;
    logic [1:0]  meta_write_state;
    logic        busy;
`ifdef PROBE_MSHR_BLOCK_EN
    logic        mshr_block_probe = 1'b0;
`endif

    probe_unit dut (
        .clock(clock), .reset(reset),
        .b_valid(b_valid), .b_ready(b_ready), .b_param(b_param),
        .b_address(b_address), .b_source(b_source),
        .meta_read_valid(meta_read_valid), .meta_read_ready(meta_read_ready),
        .meta_read_idx(meta_read_idx), .meta_read_tag(meta_read_tag),
        .meta_way_en(meta_way_en), .meta_state(meta_state),
        .c_valid(c_valid), .c_ready(c_ready), .c_param(c_param),
        .c_address(c_address), .c_source(c_source),
        .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
        .wb_req_param(wb_req_param), .wb_req_way_en(wb_req_way_en),
        .wb_req_idx(wb_req_idx), .wb_req_tag(wb_req_tag), .wb_req_source(wb_req_source),
        .wb_done(wb_done),
        .meta_write_valid(meta_write_valid), .meta_write_ready(meta_write_ready),
        .meta_write_idx(meta_write_idx), .meta_write_way_en(meta_write_way_en),
        .meta_write_tag(meta_write_tag), .meta_write_state(meta_write_state),
`ifdef PROBE_MSHR_BLOCK_EN
        .mshr_block_probe(mshr_block_probe),
`endif
        .busy(busy)
    );

    typedef struct { logic [2:0] param; logic [31:0] addr; logic [3:0] src; } c_t;
    typedef struct { logic [2:0] param; logic [3:0] way; logic [5:0] idx; logic [19:0] tag; logic [3:0] src; } wb_t;
    typedef struct { logic [5:0] idx; logic [3:0] way; logic [19:0] tag; logic [1:0] st; } mw_t;

    c_t  exp_c[$];
    wb_t exp_wb[$];
    mw_t exp_mw[$];
    c_t  got_c;
    wb_t got_wb;
    mw_t got_mw;

    int n_checks = 0;
    int n_fail   = 0;

    logic       rand_mode = 1'b0;
    logic       f_mr = 1'b1, f_c = 1'b1, f_wb = 1'b1, f_mw = 1'b1;
    int         wb_delay = 0;
    logic [3:0] next_way = 4'd0;
    logic [1:0] next_state = 2'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clock) begin
        #1;
        if (rand_mode) begin
            meta_read_ready  = ($urandom_range(0, 3) != 0);
            c_ready          = ($urandom_range(0, 3) != 0);
            wb_req_ready     = ($urandom_range(0, 3) != 0);
            meta_write_ready = ($urandom_range(0, 3) != 0);
        end else begin
            meta_read_ready  = f_mr;
            c_ready          = f_c;
            wb_req_ready     = f_wb;
            meta_write_ready = f_mw;
        end
    end

    // The array answers the cycle after the read handshake.
    always @(negedge clock) begin
        if (!reset && meta_read_valid && meta_read_ready) begin
            @(posedge clock);
            #1;
            meta_way_en = next_way;
            meta_state  = next_state;
        end
    end

    always @(negedge clock) begin
        if (!reset && wb_req_valid && wb_req_ready) begin
            @(posedge clock);
            repeat (wb_delay) @(posedge clock);
            #1 wb_done = 1'b1;
            @(posedge clock);
            #1 wb_done = 1'b0;
        end
    end

    logic        c_hold = 1'b0;
    logic [2:0]  h_param;
    logic [31:0] h_addr;
    logic [3:0]  h_src;

    always @(negedge clock) begin
        if (reset) begin
            c_hold = 1'b0;
        end else begin
            check("b_ready_while_busy", 64'(b_ready && busy), 64'd0);
            if (c_hold) begin
                check("c_hold_valid", 64'(c_valid), 64'd1);
                check("c_hold_param", 64'(c_param), 64'(h_param));
                check("c_hold_addr", 64'(c_address), 64'(h_addr));
                check("c_hold_src", 64'(c_source), 64'(h_src));
            end
            c_hold  = c_valid && !c_ready;
            h_param = c_param;
            h_addr  = c_address;
            h_src   = c_source;

            if (c_valid && c_ready) begin
                if (exp_c.size() == 0) check("c_unexpected", 64'd1, 64'd0);
                else begin
                    got_c = exp_c.pop_front();
                    check("c_param", 64'(c_param), 64'(got_c.param));
                    check("c_address", 64'(c_address), 64'(got_c.addr));
                    check("c_source", 64'(c_source), 64'(got_c.src));
                end
            end
            if (wb_req_valid && wb_req_ready) begin
                if (exp_wb.size() == 0) check("wb_unexpected", 64'd1, 64'd0);
                else begin
                    got_wb = exp_wb.pop_front();
                    check("wb_param", 64'(wb_req_param), 64'(got_wb.param));
                    check("wb_way", 64'(wb_req_way_en), 64'(got_wb.way));
                    check("wb_idx", 64'(wb_req_idx), 64'(got_wb.idx));
                    check("wb_tag", 64'(wb_req_tag), 64'(got_wb.tag));
                    check("wb_source", 64'(wb_req_source), 64'(got_wb.src));
                end
            end
            if (meta_write_valid && meta_write_ready) begin
                if (exp_mw.size() == 0) check("mw_unexpected", 64'd1, 64'd0);
                else begin
                    got_mw = exp_mw.pop_front();
                    check("mw_idx", 64'(meta_write_idx), 64'(got_mw.idx));
                    check("mw_way", 64'(meta_write_way_en), 64'(got_mw.way));
                    check("mw_tag", 64'(meta_write_tag), 64'(got_mw.tag));
                    check("mw_state", 64'(meta_write_state), 64'(got_mw.st));
                end
            end
        end
    end

    // Reference model: permissions as levels N=0 < B=1 < T=2 (Dirty is T holding data);
    // the probe caps the level, and the report names the old and new level.
    task automatic push_expect(input logic [1:0] cap, input logic [31:0] addr, input logic [3:0] src,
                               input logic [3:0] way, input logic [1:0] st);
        int old_l, cap_l, new_l;
        logic [2:0] rep;
        logic hit;
        c_t ce;
        wb_t we;
        mw_t me;
        hit   = (way != 4'd0);
        old_l = !hit ? 0 : (st == 2'd3 ? 2 : int'(st));
        cap_l = (cap == 2'd0) ? 2 : (cap == 2'd1) ? 1 : 0;
        new_l = (old_l < cap_l) ? old_l : cap_l;
        if (old_l == new_l) rep = (old_l == 2) ? 3'd3 : (old_l == 1) ? 3'd4 : 3'd5;
        else if (old_l == 2) rep = (new_l == 1) ? 3'd0 : 3'd1;
        else rep = 3'd2;
        if (hit && st == 2'd3) begin
            we.param = rep; we.way = way; we.idx = addr[11:6]; we.tag = addr[31:12]; we.src = src;
            exp_wb.push_back(we);
        end else begin
            ce.param = rep; ce.addr = addr; ce.src = src;
            exp_c.push_back(ce);
        end
        if (hit) begin
            me.idx = addr[11:6]; me.way = way; me.tag = addr[31:12]; me.st = 2'(new_l);
            exp_mw.push_back(me);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends b-fire cycle.
    task automatic issue(input logic [1:0] cap, input logic [31:0] addr, input logic [3:0] src,
                         input logic [3:0] way, input logic [1:0] st);
        int t;
        push_expect(cap, addr, src, way, st);
        next_way   = way;
        next_state = st;
        b_param    = cap;
        b_address  = addr;
        b_source   = src;
        b_valid    = 1'b1;
        t = 0;
        @(negedge clock);
        while (!b_ready && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (!b_ready) check("b_fire_timeout", 64'd1, 64'd0);
        @(posedge clock);
        #1 b_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clock);
        while (!b_ready && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (!b_ready) check({name, "_idle_timeout"}, 64'd1, 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_fire_wb(input string name);
        int t;
        t = 0;
        @(negedge clock);
        while (!(wb_req_valid && wb_req_ready) && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (!(wb_req_valid && wb_req_ready)) check({name, "_wb_timeout"}, 64'd1, 64'd0);
        @(posedge clock);
        #1;
    endtask

    // Flags per cycle: {b_ready, meta_read_valid, c_valid, wb_req_valid, meta_write_valid}.
    task automatic timed(input string name, input int n, input logic [79:0] e);
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            check($sformatf("%s_cyc%0d", name, k),
                  64'({b_ready, meta_read_valid, c_valid, wb_req_valid, meta_write_valid}),
                  64'(e[k*5 +: 5]));
            @(posedge clock);
            #1;
        end
    endtask

    logic [79:0] e_hit, e_miss;

    initial begin
        reset = 1'b1;
        b_valid = 1'b0;
        b_param = 2'd0;
        b_address = 32'd0;
        b_source = 4'd0;
        e_hit = '0;
        e_hit[5 +: 5]  = 5'b01000;
        e_hit[20 +: 5] = 5'b00100;
        e_hit[25 +: 5] = 5'b00001;
        e_hit[30 +: 5] = 5'b10000;
        e_miss = '0;
        e_miss[5 +: 5]  = 5'b01000;
        e_miss[20 +: 5] = 5'b00100;
        e_miss[25 +: 5] = 5'b10000;
        e_miss[30 +: 5] = 5'b10000;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check("rst_b_ready", 64'(b_ready), 64'd1);
        check("rst_valids", 64'({meta_read_valid, c_valid, wb_req_valid, meta_write_valid}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_c_address", 64'(c_address), 64'd0);
        check("rst_c_source", 64'(c_source), 64'd0);
        check("rst_mw_way", 64'(meta_write_way_en), 64'd0);
        @(posedge clock);
        #1;

        issue(2'd2, 32'hABCD_1240, 4'd5, 4'b0100, 2'd2);
        timed("hit_toN_trunk", 6, e_hit);

        issue(2'd0, 32'h1234_5680, 4'd9, 4'b0000, 2'd2);
        timed("miss_toT", 6, e_miss);

        wb_delay = 10;
        issue(2'd1, 32'h0F0F_0FC0, 4'd3, 4'b0001, 2'd3);
        wait_fire_wb("dirty_toB");
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("dirty_no_mw_before_done", 64'(meta_write_valid), 64'd0);
            @(posedge clock);
            #1;
        end
        wait_idle("dirty_toB");

        f_c = 1'b0;
        issue(2'd2, 32'h5555_0A40, 4'd12, 4'b1000, 2'd1);
        begin
            int t;
            t = 0;
            @(negedge clock);
            while (!c_valid && t < 50) begin
                @(negedge clock);
                t++;
            end
            for (int i = 0; i < 7; i++) begin
                check("c_stall_valid", 64'(c_valid), 64'd1);
                check("c_stall_b_ready", 64'(b_ready), 64'd0);
                @(negedge clock);
            end
        end
        f_c = 1'b1;
        wait_idle("c_stall");

`ifdef PROBE_MSHR_BLOCK_EN
        begin
            logic [79:0] e_blk;
            e_blk = '0;
            e_blk[5 +: 5]  = 5'b01000;
            e_blk[35 +: 5] = 5'b00100;
            e_blk[40 +: 5] = 5'b00001;
            e_blk[45 +: 5] = 5'b10000;
            mshr_block_probe = 1'b1;
            issue(2'd1, 32'h2222_3340, 4'd7, 4'b0100, 2'd2);
            for (int k = 1; k <= 9; k++) begin
                if (k == 6) mshr_block_probe = 1'b0;
                @(negedge clock);
                check($sformatf("mshr_block_cyc%0d", k),
                      64'({b_ready, meta_read_valid, c_valid, wb_req_valid, meta_write_valid}),
                      64'(e_blk[k*5 +: 5]));
                @(posedge clock);
                #1;
            end
        end
`endif

        wb_delay = 20;
        issue(2'd0, 32'h7777_8880, 4'd1, 4'b0010, 2'd3);
        wait_fire_wb("rst_wb");
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        exp_mw.delete();
        @(negedge clock);
        check("midrst_valids", 64'({meta_read_valid, c_valid, wb_req_valid, meta_write_valid}), 64'd0);
        check("midrst_b_ready", 64'(b_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (30) @(negedge clock);
        check("late_wb_done_ignored", 64'(b_ready), 64'd1);
        @(posedge clock);
        #1;

        rand_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [3:0] w;
            wb_delay = int'($urandom_range(0, 4));
            w = ($urandom_range(0, 2) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            issue(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)), w,
                  2'($urandom_range(0, 3)));
            wait_idle("rand");
        end
        rand_mode = 1'b0;
        repeat (3) @(posedge clock);

        check("exp_c_drained", 64'(exp_c.size()), 64'd0);
        check("exp_wb_drained", 64'(exp_wb.size()), 64'd0);
        check("exp_mw_drained", 64'(exp_mw.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
